double_result_fifo: RTL and testbench
=====================================

# double_result_fifo

Result-side buffer that sits directly downstream of `double_adder`. It consumes the adder's 64-bit `output_z` through the team's stb/ack handshake and queues the results in a small FIFO. Software drains the results over an Avalon-MM slave port, so the adder is never held waiting for a bus read. Status, a flush, and sticky statistics are exposed as memory-mapped registers on the same port.

## Interface

Parameters:
- `DEPTH`, default 8: FIFO entries. Must be a power of two, 2..64.
- `CNT_W`, default $clog2(DEPTH)+1: occupancy counter width.

Ports:
- `clk`, in, 1: single clock, all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `input_z`, in, 64: result word from `double_adder` `output_z`.
- `input_z_stb`, in, 1: result valid; connects to `output_z_stb`.
- `input_z_ack`, out, 1: result accepted; drives the adder's `output_z_ack`.
- `address`, in, 3: Avalon word address.
- `read`, in, 1: Avalon read request.
- `write`, in, 1: Avalon write request.
- `writedata`, in, 64: Avalon write data.
- `byteenable`, in, 8: Avalon byte enables.
- `readdata`, out, 64: Avalon read data.
- `waitrequest`, out, 1: Avalon stall.

## Operation

Register map:
- **0, POP (read-only).** A read returns the FIFO head and pops it. Writes are ignored.
- **1, STATUS (read-only).**
  - [CNT_W-1:0] count.
  - [8] empty.
  - [9] full.
  - [16] sticky backpressure: `input_z_stb` was seen while the FIFO was full.
  - [63:32] total results accepted; wraps modulo 2^32.
- **2, CTRL (write-only).** Effective only when byteenable[0]=1.
  - writedata[0]=1: flush. Pointers and count go to 0; stored data is discarded.
  - writedata[1]=1: clear the sticky bit and the total counter.
  - Both bits may be set in the same write.
- **3–7:** reads return 0; writes are ignored.

Push:
- `input_z_ack` = !full, combinational from registered state.
- A transfer occurs at the edge where `input_z_stb && input_z_ack`.
- On a transfer, `input_z` is written at the tail, the tail increments, and the total counter increments.

Pop:
- `waitrequest` = read && address==0 && empty, combinational.
- A read to address 0 while the FIFO is non-empty completes in its first cycle:
  - `readdata` = head entry, combinational.
  - The head increments at that edge.
- Reads of other addresses never stall. `readdata` is the combinational mux of the register for the current address, and is 0 when `read`=0.
- Writes never stall.

Boundary rules:
- **Push and pop in the same cycle, non-empty and not full:** both occur and the count is unchanged.
- **Full:** the pop is allowed. The push is refused that cycle because ack was low before the edge. Ack rises the following cycle.
- **Empty:** a pop read stalls. A push in the same cycle lands, and the read completes next cycle with that word.
- **Flush together with a push or pop:** flush wins. The push is dropped, but the total counter still increments because the adder saw an ack. The pop does not occur.
- **Pointer wrap:** pointers wrap modulo DEPTH. Full and empty are derived from the count, never from pointer equality.
- **Reset mid-operation:** asynchronous clear of pointers, count, sticky bit and total counter. The storage array is not reset.

## Timing

- Reset values:
  - `input_z_ack`=1, because the FIFO is empty.
  - `waitrequest`=0 when no read is pending.
  - `readdata`=0.
- Push-to-pop latency: a word accepted at edge N can be read in the cycle after edge N.
- Throughput: one push and one pop per cycle.
- STATUS reflects the state after the most recent edge. No bypass of same-cycle events.
- No combinational path from `input_z_stb` to `input_z_ack`.

## Structure

- Package `double_fifo_pkg`:
  - Address constants ADDR_POP, ADDR_STATUS, ADDR_CTRL.
  - STATUS bit positions.
  - CTRL bit positions.
- Sub-module `sync_fifo_mem`:
  - Storage array, head/tail pointers, count.
  - Push, pop and flush inputs.
  - The top level owns the Avalon decode, the handshake and the statistics.

## Test plan

1. **Basic push and pop.** Reset, push 64'h3FF0000000000000, then read address 0 → readdata=64'h3FF0000000000000 with no wait. STATUS count=0, empty=1, total=1.
2. **Fill to capacity.** Push 8 words with stb held high → ack low after the 8th and the 9th word is held. STATUS full=1, sticky=1. Pop once → ack=1 next cycle and the 9th word is accepted.
3. **Stalled read.** Read address 0 while empty → waitrequest=1. Push 64'hC000000000000000 at edge N → the read completes in the following cycle with that value.
4. **Simultaneous push and pop at count 4, plus wrap.** Count stays 4. Run 20 words through in order → output order matches input.
5. **Flush.** Flush together with a push → count=0, empty=1, total incremented. A CTRL write of 2 → total=0, sticky=0.
6. **Reset mid-operation.** Assert reset mid-stream with count=5 → outputs return immediately to the reset values and count=0.

Source files
------------

// File: rtl/double_fifo_pkg.sv
// double_fifo_pkg: register map and bit positions for double_result_fifo
package double_fifo_pkg;
  localparam logic [2:0] ADDR_POP    = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam int STAT_EMPTY     = 8;
  localparam int STAT_FULL      = 9;
  localparam int STAT_STICKY    = 16;
  localparam int STAT_TOTAL_LSB = 32;
  localparam int CTRL_FLUSH     = 0;
  localparam int CTRL_CLEAR     = 1;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: storage, pointers and count for a power-of-two FIFO with flush
module sync_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CNT_W-1:0] r_count;
  always_ff @(posedge clk)
    if (push && !flush) r_mem[r_tail] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_tail <= r_tail + 1'b1;
      if (pop) r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
    end
  assign rdata = r_mem[r_head];
  assign count = r_count;
  assign empty = r_count == '0;
  assign full  = r_count == CNT_W'(DEPTH);
endmodule

// File: rtl/double_result_fifo.sv
// double_result_fifo: queues double_adder results for draining over Avalon-MM
module double_result_fifo
  import double_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] input_z,
  input  logic        input_z_stb,
  output logic        input_z_ack,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [63:0] writedata,
  input  logic [7:0]  byteenable,
  output logic [63:0] readdata,
  output logic        waitrequest
);
  logic [63:0]      w_head;
  logic [63:0]      w_status;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_ctrl_wr;
  logic             w_flush;
  logic             w_clear;
  logic             r_sticky;
  logic [31:0]      r_total;
  assign input_z_ack = !w_full;
  assign w_push      = input_z_stb && input_z_ack;
  assign w_pop       = read && address == ADDR_POP && !w_empty;
  assign waitrequest = read && address == ADDR_POP && w_empty;
  assign w_ctrl_wr   = write && address == ADDR_CTRL && byteenable[0];
  assign w_flush     = w_ctrl_wr && writedata[CTRL_FLUSH];
  assign w_clear     = w_ctrl_wr && writedata[CTRL_CLEAR];
  sync_fifo_mem #(.DEPTH(DEPTH), .W(64), .CNT_W(CNT_W)) u_mem (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata (input_z),
    .rdata (w_head),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );
  // total counts every handshake, including one dropped by a same-cycle flush
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sticky <= 1'b0;
      r_total  <= '0;
    end else if (w_clear) begin
      r_sticky <= 1'b0;
      r_total  <= '0;
    end else begin
      if (input_z_stb && w_full) r_sticky <= 1'b1;
      r_total <= r_total + 32'(w_push);
    end
  always_comb begin
    w_status                                   = '0;
    w_status[CNT_W-1:0]                        = w_count;
    w_status[STAT_EMPTY]                       = w_empty;
    w_status[STAT_FULL]                        = w_full;
    w_status[STAT_STICKY]                      = r_sticky;
    w_status[STAT_TOTAL_LSB+:32]               = r_total;
    readdata = !read ? '0 :
               address == ADDR_POP    ? w_head :
               address == ADDR_STATUS ? w_status : '0;
  end
endmodule

// File: tb/tb_double_result_fifo.sv
// tb_double_result_fifo: directed scenario tests for double_result_fifo
module tb_double_result_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] input_z = '0;
  logic        input_z_stb = 1'b0;
  logic        input_z_ack;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [63:0] writedata = '0;
  logic [7:0]  byteenable = '0;
  logic [63:0] readdata;
  logic        waitrequest;
  int          n_vec = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  double_result_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .input_z     (input_z),
    .input_z_stb (input_z_stb),
    .input_z_ack (input_z_ack),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata),
    .waitrequest (waitrequest)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic read_status(output logic [63:0] s);
    read = 1'b1;
    address = 3'd1;
    #1 s = readdata;
    read = 1'b0;
    address = 3'd0;
  endtask
  task automatic ctrl_write(input logic [63:0] d, input logic [7:0] be);
    write = 1'b1;
    address = 3'd2;
    writedata = d;
    byteenable = be;
    tick();
    write = 1'b0;
    address = 3'd0;
    byteenable = '0;
  endtask
  task automatic test_reset;
    logic [63:0] s;
    tick();
    n_vec++; if (input_z_ack !== 1'b1) begin n_err++; $display("FAIL reset_ack got %b want 1", input_z_ack); end
    n_vec++; if (waitrequest !== 1'b0) begin n_err++; $display("FAIL reset_wait got %b want 0", waitrequest); end
    n_vec++; if (readdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", readdata); end
    reset = 1'b0;
    read_status(s);
    n_vec++; if (s !== 64'h100) begin n_err++; $display("FAIL reset_status got %h want %h", s, 64'h100); end
  endtask
  task automatic test_basic;
    logic [63:0] s;
    input_z = 64'h3FF0000000000000;
    input_z_stb = 1'b1;
    tick();
    input_z_stb = 1'b0;
    read = 1'b1;
    address = 3'd0;
    #1;
    n_vec++; if (waitrequest !== 1'b0) begin n_err++; $display("FAIL basic_wait got %b want 0", waitrequest); end
    n_vec++; if (readdata !== 64'h3FF0000000000000) begin n_err++; $display("FAIL basic_pop got %h want 3ff0000000000000", readdata); end
    tick();
    read = 1'b0;
    read_status(s);
    n_vec++; if (s !== 64'h0000_0001_0000_0100) begin n_err++; $display("FAIL basic_status got %h want 0000000100000100", s); end
  endtask
  task automatic test_fill;
    logic [63:0] s;
    input_z_stb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      input_z = 64'h100 + 64'(k);
      tick();
    end
    n_vec++; if (input_z_ack !== 1'b0) begin n_err++; $display("FAIL fill_ack_low got %b want 0", input_z_ack); end
    input_z = 64'h108;
    tick();
    read_status(s);
    n_vec++; if (s[15:0] !== 16'h0208) begin n_err++; $display("FAIL fill_cnt_full got %h want 0208", s[15:0]); end
    n_vec++; if (s[16] !== 1'b1) begin n_err++; $display("FAIL fill_sticky got %b want 1", s[16]); end
    read = 1'b1;
    address = 3'd0;
    #1;
    n_vec++; if (readdata !== 64'h100) begin n_err++; $display("FAIL fill_pop0 got %h want 100", readdata); end
    n_vec++; if (input_z_ack !== 1'b0) begin n_err++; $display("FAIL fill_ack_at_pop got %b want 0", input_z_ack); end
    tick();
    read = 1'b0;
    n_vec++; if (input_z_ack !== 1'b1) begin n_err++; $display("FAIL fill_ack_rise got %b want 1", input_z_ack); end
    tick();
    input_z_stb = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      read = 1'b1;
      address = 3'd0;
      #1;
      n_vec++; if (readdata !== 64'h100 + 64'(k)) begin n_err++; $display("FAIL fill_drain%0d got %h want %h", k, readdata, 64'h100 + 64'(k)); end
      tick();
    end
    read = 1'b0;
    read_status(s);
    n_vec++; if (s !== 64'h0000_000A_0001_0100) begin n_err++; $display("FAIL fill_status got %h want 0000000a00010100", s); end
  endtask
  task automatic test_stall;
    read = 1'b1;
    address = 3'd0;
    #1;
    n_vec++; if (waitrequest !== 1'b1) begin n_err++; $display("FAIL stall_wait got %b want 1", waitrequest); end
    input_z = 64'hC000000000000000;
    input_z_stb = 1'b1;
    tick();
    input_z_stb = 1'b0;
    #1;
    n_vec++; if (waitrequest !== 1'b0) begin n_err++; $display("FAIL stall_release got %b want 0", waitrequest); end
    n_vec++; if (readdata !== 64'hC000000000000000) begin n_err++; $display("FAIL stall_data got %h want c000000000000000", readdata); end
    tick();
    read = 1'b0;
  endtask
  task automatic test_simul;
    logic [63:0] s;
    input_z_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      input_z = 64'h500 + 64'(i);
      tick();
    end
    for (int i = 4; i < 20; i++) begin
      input_z = 64'h500 + 64'(i);
      read = 1'b1;
      address = 3'd0;
      #1;
      n_vec++; if (readdata !== 64'h500 + 64'(i - 4)) begin n_err++; $display("FAIL simul_order%0d got %h want %h", i - 4, readdata, 64'h500 + 64'(i - 4)); end
      tick();
    end
    input_z_stb = 1'b0;
    read_status(s);
    n_vec++; if (s[7:0] !== 8'd4) begin n_err++; $display("FAIL simul_count got %0d want 4", s[7:0]); end
    for (int i = 16; i < 20; i++) begin
      read = 1'b1;
      address = 3'd0;
      #1;
      n_vec++; if (readdata !== 64'h500 + 64'(i)) begin n_err++; $display("FAIL simul_tail%0d got %h want %h", i, readdata, 64'h500 + 64'(i)); end
      tick();
    end
    read = 1'b0;
    read_status(s);
    n_vec++; if (s[63:32] !== 32'd31) begin n_err++; $display("FAIL simul_total got %0d want 31", s[63:32]); end
  endtask
  task automatic test_flush;
    logic [63:0] s;
    input_z_stb = 1'b1;
    input_z = 64'hA1;
    tick();
    input_z = 64'hA2;
    tick();
    input_z = 64'hDEAD;
    ctrl_write(64'h1, 8'h01);
    input_z_stb = 1'b0;
    read_status(s);
    n_vec++; if (s !== 64'h0000_0022_0001_0100) begin n_err++; $display("FAIL flush_status got %h want 0000002200010100", s); end
    ctrl_write(64'h2, 8'hFF);
    read_status(s);
    n_vec++; if (s !== 64'h100) begin n_err++; $display("FAIL clear_status got %h want 100", s); end
    input_z_stb = 1'b1;
    input_z = 64'hB1;
    tick();
    input_z_stb = 1'b0;
    ctrl_write(64'h3, 8'hFE);
    read_status(s);
    n_vec++; if (s !== 64'h0000_0001_0000_0001) begin n_err++; $display("FAIL flush_no_be got %h want 0000000100000001", s); end
    ctrl_write(64'h3, 8'h01);
    read_status(s);
    n_vec++; if (s !== 64'h100) begin n_err++; $display("FAIL flush_clear_both got %h want 100", s); end
  endtask
  task automatic test_reset_mid;
    logic [63:0] s;
    input_z_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      input_z = 64'h700 + 64'(i);
      tick();
    end
    input_z_stb = 1'b0;
    read_status(s);
    n_vec++; if (s[7:0] !== 8'd5) begin n_err++; $display("FAIL mid_count_pre got %0d want 5", s[7:0]); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (input_z_ack !== 1'b1) begin n_err++; $display("FAIL mid_ack got %b want 1", input_z_ack); end
    n_vec++; if (waitrequest !== 1'b0) begin n_err++; $display("FAIL mid_wait got %b want 0", waitrequest); end
    n_vec++; if (readdata !== 64'h0) begin n_err++; $display("FAIL mid_rdata got %h want 0", readdata); end
    read_status(s);
    n_vec++; if (s !== 64'h100) begin n_err++; $display("FAIL mid_status got %h want 100", s); end
    reset = 1'b0;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_stall();
    test_simul();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
